// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (5..9 data bits, opt parity, 1/2 stop)
// LSB first, registered tx, valid/ready input, internal baud divider.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 done,
    output logic                 busy
);

    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic last_tick;
    logic par_in;

    assign in_ready  = (state_q == S_IDLE) & en & rst_n;
    assign last_tick = (div_q == DIV_LAST);
    assign par_in    = (PARITY == 1) ? ~^in_data : ^in_data;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state: bit timing, shifting out the word and framing outputs
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (en) begin
            if (state_q != S_IDLE) begin
                div_d = last_tick ? '0 : div_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_d = in_data;
                        par_d   = par_in;
                        div_d   = '0;
                        idx_d   = '0;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_START: begin
                    if (last_tick) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        tx_d    = shift_q[0];
                    end
                end
                S_DATA: begin
                    if (last_tick) begin
                        if (idx_q == DATA_LAST) begin
                            idx_d = '0;
                            if (PARITY != 0) begin
                                state_d = S_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (last_tick) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end
                end
                S_STOP: begin
                    if (last_tick) begin
                        if (idx_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                        tx_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param with four parameter sets
// sharing clock, reset and enable; all use 4 clocks per bit.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] d8;
    logic       valid [4];
    logic       rdy_w [4];
    logic       tx_w  [4];
    logic       done_w[4];
    logic       busy_w[4];

    int cnt = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // edge counter read at negedges
    always @(posedge clk) cnt <= cnt + 1;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(d8), .in_valid(valid[0]),
        .in_ready(rdy_w[0]), .tx(tx_w[0]), .done(done_w[0]), .busy(busy_w[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(d8), .in_valid(valid[1]),
        .in_ready(rdy_w[1]), .tx(tx_w[1]), .done(done_w[1]), .busy(busy_w[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(d8), .in_valid(valid[2]),
        .in_ready(rdy_w[2]), .tx(tx_w[2]), .done(done_w[2]), .busy(busy_w[2]));
    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(d8[4:0]), .in_valid(valid[3]),
        .in_ready(rdy_w[3]), .tx(tx_w[3]), .done(done_w[3]), .busy(busy_w[3]));

    typedef struct {
        int          id;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] frame;
        int          done_at;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one word on DUT id and capture its frame, done offset and pulse width
    task automatic run_frame(input int id, input logic [7:0] data, input int nbits,
                             output logic [11:0] frame, output int done_at,
                             output int done_cnt);
        int w;
        frame    = '0;
        done_at  = -1;
        done_cnt = 0;
        @(negedge clk);
        d8 = data;
        valid[id] = 1'b1;
        w = 0;
        while (rdy_w[id] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(rdy_w[id]), 32'd1);
        @(posedge clk);
        #1;
        valid[id] = 1'b0;
        d8 = ~data;
        for (int c = 0; c < nbits * CPB + 20; c++) begin
            @(negedge clk);
            if (c % CPB == 1 && c / CPB < nbits) frame[c / CPB] = tx_w[id];
            if (done_w[id] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
    endtask

    logic [11:0] fr;
    int          dat;
    int          dcnt;

    initial begin
        foreach (valid[i]) valid[i] = 1'b0;
        rst_n = 1'b0;
        en    = 1'b1;
        d8    = '0;

        vecs[0]  = '{0, 8'hA5, 10, 12'({1'b1, 8'hA5, 1'b0}), 40};
        vecs[1]  = '{0, 8'h00, 10, 12'({1'b1, 8'h00, 1'b0}), 40};
        vecs[2]  = '{0, 8'hFF, 10, 12'({1'b1, 8'hFF, 1'b0}), 40};
        vecs[3]  = '{0, 8'h3C, 10, 12'({1'b1, 8'h3C, 1'b0}), 40};
        vecs[4]  = '{1, 8'h07, 11, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 44};
        vecs[5]  = '{2, 8'h07, 11, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 44};
        vecs[6]  = '{1, 8'h03, 11, 12'({1'b1, 1'b0, 8'h03, 1'b0}), 44};
        vecs[7]  = '{2, 8'h01, 11, 12'({1'b1, 1'b0, 8'h01, 1'b0}), 44};
        vecs[8]  = '{3, 8'h1F, 8, 12'({2'b11, 5'h1F, 1'b0}), 32};
        vecs[9]  = '{3, 8'hE0, 8, 12'({2'b11, 5'h00, 1'b0}), 32};
        vecs[10] = '{3, 8'hEA, 8, 12'({2'b11, 5'h0A, 1'b0}), 32};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx_w[0]), 32'd1);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_ready", 32'(rdy_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy_w[0]), 32'd1);
        chk("ready_after_rst_u3", 32'(rdy_w[3]), 32'd1);
        en = 1'b0;
        #1;
        chk("ready_en_low", 32'(rdy_w[0]), 32'd0);
        @(negedge clk);
        en = 1'b1;

        // table of single frames
        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].id, vecs[i].data, vecs[i].nbits, fr, dat, dcnt);
            chk($sformatf("frame_v%0d", i), 32'(fr), 32'(vecs[i].frame));
            chk($sformatf("done_at_v%0d", i), 32'(dat), 32'(vecs[i].done_at));
            chk($sformatf("done_width_v%0d", i), 32'(dcnt), 32'd1);
        end

        // back-to-back frames with in_valid held
        begin
            logic [7:0] w[3];
            int         acc_t[3];
            int         done_t[3];
            logic [9:0] bf[3];
            int         acc_n;
            int         kd;
            int         rdy_bad;
            bit         pend;
            w = '{8'h3C, 8'hC3, 8'h81};
            acc_n = 0;
            kd = 0;
            rdy_bad = 0;
            pend = 0;
            foreach (done_t[j]) begin
                done_t[j] = -1000;
                acc_t[j] = 0;
                bf[j] = '0;
            end
            @(negedge clk);
            d8 = w[0];
            valid[0] = 1'b1;
            for (int c = 0; c < 200; c++) begin
                if (pend) begin
                    pend = 0;
                    if (acc_n < 3) d8 = w[acc_n];
                    else valid[0] = 1'b0;
                end
                if (done_w[0] === 1'b1 && kd < 3) begin
                    done_t[kd] = cnt;
                    kd++;
                end
                if (valid[0] && kd > 0 && rdy_w[0] === 1'b1 && done_w[0] !== 1'b1)
                    rdy_bad++;
                for (int j = 0; j < acc_n; j++) begin
                    int off;
                    off = cnt - acc_t[j];
                    if (off >= 1 && off % CPB == 1 && off / CPB < 10)
                        bf[j][off / CPB] = tx_w[0];
                end
                if (valid[0] && rdy_w[0] === 1'b1 && acc_n < 3) begin
                    acc_t[acc_n] = cnt + 1;
                    acc_n++;
                    pend = 1;
                end
                @(negedge clk);
            end
            chk("b2b_accepts", 32'(acc_n), 32'd3);
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("b2b_frame%0d", j), 32'(bf[j]), 32'({1'b1, w[j], 1'b0}));
                chk($sformatf("b2b_done%0d", j), 32'(done_t[j] - acc_t[j]), 32'd40);
                if (j > 0)
                    chk($sformatf("b2b_gap%0d", j), 32'(acc_t[j] - done_t[j-1]), 32'd1);
            end
            chk("b2b_ready_only_on_done", 32'(rdy_bad), 32'd0);
        end

        // enable low for 7 clocks in the middle of data bit d[1]
        begin
            int w;
            int dc;
            int held_bad;
            int eff;
            logic lvl;
            logic [11:0] ff;
            @(negedge clk);
            d8 = 8'hA5;
            valid[0] = 1'b1;
            w = 0;
            while (rdy_w[0] !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("frz_accept_ready", 32'(rdy_w[0]), 32'd1);
            @(posedge clk);
            #1;
            valid[0] = 1'b0;
            ff = '0;
            dc = -1;
            held_bad = 0;
            lvl = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                eff = (c <= 9) ? c : c - 7;
                if ((c <= 9 || c >= 17) && eff % CPB == 1 && eff / CPB < 10)
                    ff[eff / CPB] = tx_w[0];
                if (c >= 10 && c <= 16) begin
                    if (tx_w[0] !== lvl || done_w[0] !== 1'b0 || rdy_w[0] !== 1'b0)
                        held_bad++;
                end
                if (c == 9) begin
                    lvl = tx_w[0];
                    en = 1'b0;
                end
                if (c == 16) en = 1'b1;
                if (done_w[0] === 1'b1 && dc < 0) dc = c;
            end
            chk("frz_frame", 32'(ff), 32'({1'b1, 8'hA5, 1'b0}));
            chk("frz_done_at", 32'(dc), 32'd47);
            chk("frz_held", 32'(held_bad), 32'd0);
        end

        // reset during data bit d[2]
        begin
            int w;
            int dn;
            @(negedge clk);
            d8 = 8'h00;
            valid[0] = 1'b1;
            w = 0;
            while (rdy_w[0] !== 1'b1 && w < 100) begin
                @(negedge clk);
                w++;
            end
            @(posedge clk);
            #1;
            valid[0] = 1'b0;
            for (int c = 0; c < 14; c++) @(negedge clk);
            chk("pre_rst_tx", 32'(tx_w[0]), 32'd0);
            chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
            rst_n = 1'b0;
            @(negedge clk);
            chk("mid_rst_tx", 32'(tx_w[0]), 32'd1);
            chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
            rst_n = 1'b1;
            dn = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (done_w[0] === 1'b1) dn++;
            end
            chk("mid_rst_no_done", 32'(dn), 32'd0);
            run_frame(0, 8'h5A, 10, fr, dat, dcnt);
            chk("post_rst_frame", 32'(fr), 32'({1'b1, 8'h5A, 1'b0}));
            chk("post_rst_done_at", 32'(dat), 32'd40);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
